// File: rtl/axis_lrelu_config_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_lrelu_config_sequencer_if
// Description : AXI4-Stream style bundle shared by the config, data and merged
//               output streams of the LReLU config sequencer.
// Signals     : tvalid/tready/tlast handshake, tdata [WORD_WIDTH],
//               tuser [TUSER_WIDTH].
// Modports    : master drives payload and tvalid; slave drives tready.
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_lrelu_config_sequencer_if #(
   parameter int WORD_WIDTH  = 64,
   parameter int TUSER_WIDTH = 8
);
   logic                   tvalid;
   logic                   tready;
   logic                   tlast;
   logic [WORD_WIDTH-1:0]  tdata;
   logic [TUSER_WIDTH-1:0] tuser;

   modport master (output tvalid, output tlast, output tdata, output tuser,
                   input  tready);
   modport slave  (input  tvalid, input  tlast, input  tdata, input  tuser,
                   output tready);
endinterface
`default_nettype wire

// File: rtl/axis_lrelu_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : axis_lrelu_config_sequencer
// Description : Merges a config stream and a conv-output data stream into one
//               stream for the LReLU engine. Each iteration forwards N config
//               beats (N from the is-1x1 tuser flag) followed by data beats up
//               to the data tlast, through a 2-entry registered skid buffer.
// Ports       : aclk, areset   - clock, synchronous active-high reset
//               s_cfg  (slave) - config stream
//               s_data (slave) - data stream
//               m      (master)- merged output stream
//               iter_count     - completed iterations (wrapping)
//               cfg_error      - sticky config-length mismatch flag
// Revision    : 1.0 - initial release
// ============================================================================
module axis_lrelu_config_sequencer #(
   parameter int WORD_WIDTH  = 64,
   parameter int TUSER_WIDTH = 8,
   parameter int I_IS_1X1    = 0,
   parameter int BEATS_3X3   = 9,
   parameter int BEATS_1X1   = 5
) (
   input  logic                           aclk,
   input  logic                           areset,
   axis_lrelu_config_sequencer_if.slave   s_cfg,
   axis_lrelu_config_sequencer_if.slave   s_data,
   axis_lrelu_config_sequencer_if.master  m,
   output logic [15:0]                    iter_count,
   output logic                           cfg_error
);

   typedef enum logic [1:0] {
      CFG_FIRST = 2'd0,
      CFG_REST  = 2'd1,
      DATA      = 2'd2
   } state_t;

   state_t                  r_state;
   logic [15:0]             r_cnt;
   logic [15:0]             r_iter;
   logic                    r_err;
   // Held low for the first cycle after reset so both treadys read 0 there.
   logic                    r_rdy;
   // Skid entries: slot 0 is the head presented on m, slot 1 the overflow.
   logic                    r_v0, r_v1;
   logic                    r_l0, r_l1;
   logic [WORD_WIDTH-1:0]   r_d0, r_d1;
   logic [TUSER_WIDTH-1:0]  r_u0, r_u1;

   logic                    w_buf_rdy;
   logic                    w_cfg_hs;
   logic                    w_dat_hs;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_slot0;
   logic                    w_in_last;
   logic [WORD_WIDTH-1:0]   w_in_data;
   logic [TUSER_WIDTH-1:0]  w_in_user;
   logic [15:0]             w_n_first;
   logic                    w_nth;

   // Readiness comes only from registered occupancy; m.tready never reaches it.
   assign w_buf_rdy    = r_rdy & ~r_v1;
   assign s_cfg.tready  = w_buf_rdy & (r_state != DATA);
   assign s_data.tready = w_buf_rdy & (r_state == DATA);

   assign w_cfg_hs  = s_cfg.tvalid  & s_cfg.tready;
   assign w_dat_hs  = s_data.tvalid & s_data.tready;
   assign w_push    = w_cfg_hs | w_dat_hs;
   assign w_pop     = r_v0 & m.tready;

   // The two streams are never ready together, so the mux select is exclusive.
   assign w_in_data = w_dat_hs ? s_data.tdata : s_cfg.tdata;
   assign w_in_user = w_dat_hs ? s_data.tuser : s_cfg.tuser;
   assign w_in_last = w_dat_hs & s_data.tlast;

   // After a pop slot 1 shifts into slot 0, so the free slot depends on the pop.
   assign w_slot0   = w_pop ? ~r_v1 : ~r_v0;

   assign w_n_first = s_cfg.tuser[I_IS_1X1] ? 16'(BEATS_1X1) : 16'(BEATS_3X3);
   // True when the config beat now on the bus is the N-th of the iteration.
   assign w_nth     = (r_state == CFG_FIRST) ? (w_n_first == 16'd1) : (r_cnt == 16'd0);

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= CFG_FIRST;
         r_cnt   <= 16'd0;
         r_iter  <= 16'd0;
         r_err   <= 1'b0;
         r_rdy   <= 1'b0;
         r_v0    <= 1'b0;
         r_v1    <= 1'b0;
         r_l0    <= 1'b0;
         r_l1    <= 1'b0;
         r_d0    <= '0;
         r_d1    <= '0;
         r_u0    <= '0;
         r_u1    <= '0;
      end else begin
         r_rdy <= 1'b1;

         if (w_pop) begin
            r_v0 <= r_v1;
            r_l0 <= r_l1;
            r_d0 <= r_d1;
            r_u0 <= r_u1;
            r_v1 <= 1'b0;
         end
         if (w_push) begin
            if (w_slot0) begin
               r_v0 <= 1'b1;
               r_l0 <= w_in_last;
               r_d0 <= w_in_data;
               r_u0 <= w_in_user;
            end else begin
               r_v1 <= 1'b1;
               r_l1 <= w_in_last;
               r_d1 <= w_in_data;
               r_u1 <= w_in_user;
            end
         end

         // A mismatching tlast only raises the flag; sequencing follows N.
         if (w_cfg_hs && (s_cfg.tlast != w_nth)) begin
            r_err <= 1'b1;
         end

         case (r_state)
            CFG_FIRST: begin
               if (w_cfg_hs) begin
                  r_cnt   <= w_n_first - 16'd2;
                  r_state <= (w_n_first == 16'd1) ? DATA : CFG_REST;
               end
            end
            CFG_REST: begin
               if (w_cfg_hs) begin
                  if (r_cnt == 16'd0) begin
                     r_state <= DATA;
                  end else begin
                     r_cnt <= r_cnt - 16'd1;
                  end
               end
            end
            DATA: begin
               if (w_dat_hs && s_data.tlast) begin
                  r_state <= CFG_FIRST;
                  r_iter  <= r_iter + 16'd1;
               end
            end
            default: r_state <= CFG_FIRST;
         endcase
      end
   end

   assign m.tvalid   = r_v0;
   assign m.tlast    = r_l0;
   assign m.tdata    = r_d0;
   assign m.tuser    = r_u0;
   assign iter_count = r_iter;
   assign cfg_error  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_lrelu_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_lrelu_config_sequencer
// Description : Directed self-checking bench for axis_lrelu_config_sequencer.
//               Input handshakes feed an expected-beat queue that every output
//               handshake is compared against; directed steps cover reset,
//               3x3 and 1x1 iterations, full-buffer stall, tlast error,
//               mid-stream reset and a randomized backpressure run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_lrelu_config_sequencer;
   localparam int W = 64;
   localparam int U = 8;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [15:0] iter_count;
   logic        cfg_error;

   always #5 aclk = ~aclk;

   axis_lrelu_config_sequencer_if #(.WORD_WIDTH(W), .TUSER_WIDTH(U)) s_cfg ();
   axis_lrelu_config_sequencer_if #(.WORD_WIDTH(W), .TUSER_WIDTH(U)) s_data ();
   axis_lrelu_config_sequencer_if #(.WORD_WIDTH(W), .TUSER_WIDTH(U)) m ();

   axis_lrelu_config_sequencer #(
      .WORD_WIDTH(W), .TUSER_WIDTH(U), .I_IS_1X1(0), .BEATS_3X3(9), .BEATS_1X1(5)
   ) u_dut (
      .aclk(aclk), .areset(areset), .s_cfg(s_cfg), .s_data(s_data), .m(m),
      .iter_count(iter_count), .cfg_error(cfg_error)
   );

   typedef struct packed {
      logic         last;
      logic [W-1:0] data;
      logic [U-1:0] user;
   } beat_t;

   int    checks = 0;
   int    errors = 0;
   beat_t q[$];
   int    cfg_in_iter = 0;
   int    data_in_iter = 0;
   int    exp_n = 9;
   int    out_beats = 0;
   int    out_lasts = 0;
   bit    rnd_bp = 1'b0;
   bit    prev_stall = 1'b0;
   beat_t prev_beat;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
      if (rnd_bp) m.tready = 1'($urandom_range(0, 1));
   endtask

   // Scoreboard and protocol monitor, sampled mid-cycle.
   always @(negedge aclk) begin
      beat_t cur, e;
      cur = '{last: m.tlast, data: m.tdata, user: m.tuser};
      if (areset) begin
         q.delete();
         cfg_in_iter  = 0;
         data_in_iter = 0;
         prev_stall   = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 80'(m.tvalid), 80'(1));
            chk("hold_payload", 80'(cur), 80'(prev_beat));
         end
         if (m.tvalid && m.tready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", 80'(1), 80'(0));
            end else begin
               e = q.pop_front();
               chk("out_beat", 80'(cur), 80'(e));
            end
            out_beats++;
            if (m.tlast) out_lasts++;
         end
         prev_stall = m.tvalid && !m.tready;
         prev_beat  = cur;
         if (s_cfg.tvalid && s_cfg.tready) begin
            q.push_back('{last: 1'b0, data: s_cfg.tdata, user: s_cfg.tuser});
            cfg_in_iter++;
         end
         if (s_data.tvalid && s_data.tready) begin
            if (data_in_iter == 0) chk("cfg_before_data", 80'(cfg_in_iter), 80'(exp_n));
            q.push_back('{last: s_data.tlast, data: s_data.tdata, user: s_data.tuser});
            data_in_iter++;
            if (s_data.tlast) begin
               cfg_in_iter  = 0;
               data_in_iter = 0;
            end
         end
      end
   end

   task automatic send_cfg_seq(input int n, input bit is1, input int last_at,
                               input bit gaps, input int err_from, input bit lat);
      for (int i = 1; i <= n; i++) begin
         logic [U-1:0] u;
         logic [W-1:0] d;
         bit hs;
         int t;
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         u = U'($urandom);
         u[0] = is1;
         d = {$urandom, $urandom};
         s_cfg.tdata  = d;
         s_cfg.tuser  = u;
         s_cfg.tlast  = (i == last_at);
         s_cfg.tvalid = 1'b1;
         t = 0;
         do begin
            hs = s_cfg.tvalid && s_cfg.tready;
            tick();
            t++;
         end while (!hs && t < 500);
         if (!hs) chk("cfg_timeout", 80'(0), 80'(1));
         s_cfg.tvalid = 1'b0;
         s_cfg.tlast  = 1'b0;
         chk("cfg_error_step", 80'(cfg_error), 80'((err_from != 0) && (i >= err_from)));
         if (lat && i == 1) begin
            chk("latency_valid", 80'(m.tvalid), 80'(1));
            chk("latency_data", 80'(m.tdata), 80'(d));
            chk("latency_tlast", 80'(m.tlast), 80'(0));
         end
      end
   endtask

   task automatic send_data_seq(input int n, input int last_at, input bit gaps);
      for (int i = 1; i <= n; i++) begin
         bit hs;
         int t;
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         s_data.tdata  = {$urandom, $urandom};
         s_data.tuser  = U'($urandom);
         s_data.tlast  = (i == last_at);
         s_data.tvalid = 1'b1;
         t = 0;
         do begin
            hs = s_data.tvalid && s_data.tready;
            tick();
            t++;
         end while (!hs && t < 500);
         if (!hs) chk("data_timeout", 80'(0), 80'(1));
         s_data.tvalid = 1'b0;
         s_data.tlast  = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((q.size() != 0 || m.tvalid) && t < 1000) begin
         tick();
         t++;
      end
      chk("drain_empty", 80'(q.size()), 80'(0));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      time t0;
      int  cyc;
      s_cfg.tvalid = 1'b0; s_cfg.tlast = 1'b0; s_cfg.tdata = '0; s_cfg.tuser = '0;
      s_data.tvalid = 1'b0; s_data.tlast = 1'b0; s_data.tdata = '0; s_data.tuser = '0;
      m.tready = 1'b1;

      // Reset state, during reset and on the first cycle after it.
      repeat (3) tick();
      chk("rst_m_tvalid", 80'(m.tvalid), 80'(0));
      chk("rst_cfg_tready", 80'(s_cfg.tready), 80'(0));
      chk("rst_data_tready", 80'(s_data.tready), 80'(0));
      chk("rst_m_tlast", 80'(m.tlast), 80'(0));
      chk("rst_iter", 80'(iter_count), 80'(0));
      chk("rst_cfg_error", 80'(cfg_error), 80'(0));
      areset = 1'b0;
      #0;
      chk("post_rst_cfg_tready", 80'(s_cfg.tready), 80'(0));
      chk("post_rst_m_tvalid", 80'(m.tvalid), 80'(0));
      tick();
      chk("cfg_tready_up", 80'(s_cfg.tready), 80'(1));
      chk("data_tready_cfg", 80'(s_data.tready), 80'(0));

      // 3x3 iteration, data tvalid held high throughout config.
      exp_n = 9; out_beats = 0; out_lasts = 0;
      t0 = $time;
      fork
         send_cfg_seq(9, 1'b0, 9, 1'b0, 0, 1'b1);
         send_data_seq(20, 20, 1'b0);
      join
      drain();
      cyc = int'(($time - t0) / 10);
      chk("3x3_beats", 80'(out_beats), 80'(29));
      chk("3x3_tlasts", 80'(out_lasts), 80'(1));
      chk("3x3_iter", 80'(iter_count), 80'(1));
      chk("3x3_cfg_error", 80'(cfg_error), 80'(0));
      chk("3x3_throughput", 80'(cyc <= 32), 80'(1));

      // 1x1 iteration.
      exp_n = 5; out_beats = 0; out_lasts = 0;
      fork
         send_cfg_seq(5, 1'b1, 5, 1'b0, 0, 1'b0);
         send_data_seq(4, 4, 1'b0);
      join
      drain();
      chk("1x1_beats", 80'(out_beats), 80'(9));
      chk("1x1_iter", 80'(iter_count), 80'(2));

      // Full buffer with m_tready low: both inputs stall, output held.
      exp_n = 5; out_beats = 0;
      m.tready = 1'b0;
      fork
         send_cfg_seq(5, 1'b1, 5, 1'b0, 0, 1'b0);
         send_data_seq(3, 3, 1'b0);
         begin
            repeat (6) tick();
            chk("full_m_tvalid", 80'(m.tvalid), 80'(1));
            chk("full_cfg_tready", 80'(s_cfg.tready), 80'(0));
            chk("full_data_tready", 80'(s_data.tready), 80'(0));
            chk("full_out_beats", 80'(out_beats), 80'(0));
            m.tready = 1'b1;
         end
      join
      drain();
      chk("stall_beats", 80'(out_beats), 80'(8));
      chk("stall_iter", 80'(iter_count), 80'(3));

      // Early config tlast on beat 7: flag sets, sequencing still takes 9 beats.
      exp_n = 9; out_beats = 0;
      fork
         send_cfg_seq(9, 1'b0, 7, 1'b0, 7, 1'b0);
         send_data_seq(5, 5, 1'b0);
      join
      drain();
      chk("err_beats", 80'(out_beats), 80'(14));
      chk("err_sticky", 80'(cfg_error), 80'(1));
      chk("err_iter", 80'(iter_count), 80'(4));

      // Reset after 12 data beats of a 3x3 iteration.
      exp_n = 9;
      send_cfg_seq(9, 1'b0, 9, 1'b0, 1, 1'b0);
      send_data_seq(12, 0, 1'b0);
      s_data.tvalid = 1'b1;
      areset = 1'b1;
      tick();
      chk("midrst_m_tvalid", 80'(m.tvalid), 80'(0));
      chk("midrst_iter", 80'(iter_count), 80'(0));
      chk("midrst_cfg_error", 80'(cfg_error), 80'(0));
      chk("midrst_data_tready", 80'(s_data.tready), 80'(0));
      s_data.tvalid = 1'b0;
      areset = 1'b0;
      tick();
      exp_n = 5; out_beats = 0;
      fork
         send_cfg_seq(5, 1'b1, 5, 1'b0, 0, 1'b0);
         send_data_seq(4, 4, 1'b0);
      join
      drain();
      chk("midrst_1x1_beats", 80'(out_beats), 80'(9));
      chk("midrst_1x1_iter", 80'(iter_count), 80'(1));

      // 100 iterations with random gaps, layer types and 50% backpressure.
      areset = 1'b1;
      tick();
      areset = 1'b0;
      tick();
      rnd_bp = 1'b1;
      for (int it = 0; it < 100; it++) begin
         bit is1;
         int nd;
         is1 = 1'($urandom_range(0, 1));
         exp_n = is1 ? 5 : 9;
         nd = $urandom_range(1, 8);
         fork
            send_cfg_seq(exp_n, is1, exp_n, 1'b1, 0, 1'b0);
            send_data_seq(nd, nd, 1'b1);
         join
      end
      rnd_bp = 1'b0;
      m.tready = 1'b1;
      drain();
      chk("rand_iter", 80'(iter_count), 80'(100));
      chk("rand_cfg_error", 80'(cfg_error), 80'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
